// File: rtl/note_sequencer_if.sv
// Host control and synth voice signals of the note sequencer (master = host, slave = sequencer).
// Defining SEQ_OCTAVE_EN adds the octave shift input.
interface note_sequencer_if #(
    parameter int STEPS = 16,
    parameter int IDX_W = $clog2(STEPS)
);
    logic             run;
    logic [IDX_W-1:0] last_step;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [19:0]      wr_data;
`ifdef SEQ_OCTAVE_EN
    logic [1:0]       octave;
`endif
    logic             trig;
    logic [11:0]      osc_count;
    logic             latch_cfg;
    logic [IDX_W-1:0] step_idx;
    logic             busy;

`ifdef SEQ_OCTAVE_EN
    modport master (output run, last_step, wr_en, wr_addr, wr_data, octave,
                    input  trig, osc_count, latch_cfg, step_idx, busy);
    modport slave  (input  run, last_step, wr_en, wr_addr, wr_data, octave,
                    output trig, osc_count, latch_cfg, step_idx, busy);
`else
    modport master (output run, last_step, wr_en, wr_addr, wr_data,
                    input  trig, osc_count, latch_cfg, step_idx, busy);
    modport slave  (input  run, last_step, wr_en, wr_addr, wr_data,
                    output trig, osc_count, latch_cfg, step_idx, busy);
`endif
endinterface

// File: rtl/note_sequencer.sv
// Step sequencer playing a STEPS-entry pattern into the synth (osc_count, latch_cfg, trig); SEQ_OCTAVE_EN adds octave shift.
// Latency: LOAD entered on the edge after run=1; every step/stop decision is taken on a prescaler tick.
// Backpressure: none; pattern writes are accepted every cycle, including while playing.
module note_sequencer #(
    parameter int TICK_DIV = 262144,
    parameter int STEPS    = 16
) (
    input logic             clk,
    input logic             rstn,
    note_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(STEPS);
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef struct packed {
        logic [3:0]  gate_len;
        logic [3:0]  step_len;
        logic [11:0] osc_count;
    } entry_t;

    typedef enum logic [1:0] {IDLE, LOAD, GATE, REL} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    entry_t           cur_q, cur_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [11:0]      osc_q, osc_d;
    entry_t           mem_q [STEPS];
    entry_t           mem_d [STEPS];
    logic             tick;

    assign tick = (state_q != IDLE) && (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        for (int i = 0; i < STEPS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (bus.wr_en) begin
            mem_d[bus.wr_addr] = entry_t'(bus.wr_data);
        end
    end

    always_comb begin
        logic        adv;
        logic        load_en;
        entry_t      load_ent;
        logic [11:0] load_osc;

        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        osc_d    = osc_q;
        adv      = 1'b0;
        load_en  = 1'b0;
        load_ent = '0;
        load_osc = '0;

        if (state_q == IDLE)
            presc_d = '0;
        else
            presc_d = tick ? '0 : presc_q + 1'b1;

        // cnt_q holds the ticks still to run in GATE/REL after the current one
        case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    load_en = 1'b1;
                end
            end
            default: begin
                if (tick) begin
                    if (!bus.run) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else if (state_q == LOAD) begin
                        if (cur_q.gate_len != 4'd0) begin
                            state_d = GATE;
                            cnt_d   = cur_q.gate_len - 4'd1;
                        end else if (cur_q.step_len != 4'd0) begin
                            state_d = REL;
                            cnt_d   = cur_q.step_len - 4'd1;
                        end else begin
                            adv = 1'b1;
                        end
                    end else if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (state_q == GATE && cur_q.step_len > cur_q.gate_len) begin
                        state_d = REL;
                        cnt_d   = cur_q.step_len - cur_q.gate_len - 4'd1;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
        endcase

        // last_step only matters here, so a mid-step change applies at the step end
        if (adv) begin
            state_d = LOAD;
            idx_d   = (idx_q >= bus.last_step) ? '0 : idx_q + 1'b1;
            load_en = 1'b1;
        end

        load_ent = mem_q[idx_d];
`ifdef SEQ_OCTAVE_EN
        load_osc = load_ent.osc_count >> bus.octave;
        if (load_osc == 12'd0)
            load_osc = 12'd1;
`else
        load_osc = load_ent.osc_count;
`endif
        if (load_en) begin
            cur_d = load_ent;
            osc_d = load_osc;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            presc_q <= '0;
            idx_q   <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            osc_q   <= '0;
            for (int i = 0; i < STEPS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            osc_q   <= osc_d;
            for (int i = 0; i < STEPS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.trig      = (state_q == GATE);
    assign bus.latch_cfg = (state_q == LOAD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.osc_count = osc_q;
    assign bus.step_idx  = idx_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with TICK_DIV=4: vector table, hand-written corner sequences,
// and randomized patterns against a step-schedule model.
module tb_note_sequencer;
    localparam int TD   = 4;
    localparam int NCYC = 300;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    note_sequencer_if bus ();
    note_sequencer #(.TICK_DIV(TD), .STEPS(16)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int g;
        int s;
        int osc;
        int exp_latch;
        int exp_trig;
        int exp_period;
    } vec_t;

    typedef struct {
        int trig;
        int latch;
        int idx;
        int osc;
    } cyc_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] ent(input int g, input int s, input int o);
        return {4'(g), 4'(s), 12'(o)};
    endfunction

    task automatic wr(input int a, input logic [19:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(a);
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic stop_play();
        int c;
        bus.run = 1'b0;
        c = 0;
        while (bus.busy && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("stop_busy", int'(bus.busy), 0);
        chk("stop_idx", int'(bus.step_idx), 0);
        chk("stop_trig", int'(bus.trig), 0);
    endtask

    task automatic next_step(output int idx);
        int cur;
        int c;
        cur = int'(bus.step_idx);
        c   = 0;
        do begin
            @(negedge clk);
            c++;
        end while (int'(bus.step_idx) == cur && c < 200);
        chk("step_change_in_time", int'(c < 200), 1);
        idx = int'(bus.step_idx);
    endtask

    task automatic wait_trig(input string name);
        int c;
        c = 0;
        while (!bus.trig && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk(name, int'(bus.trig), 1);
    endtask

    vec_t tbl[7];

    initial begin
        int idx;
        tbl[0] = '{2,  3,  'h123, 4, 8,  16};
        tbl[1] = '{0,  2,  'h050, 4, 0,  12};
        tbl[2] = '{3,  1,  'h0A5, 4, 12, 16};
        tbl[3] = '{0,  0,  'h777, 4, 0,  4};
        tbl[4] = '{15, 15, 'hFFF, 4, 60, 64};
        tbl[5] = '{1,  15, 'h801, 4, 4,  64};
        tbl[6] = '{15, 0,  'h0F0, 4, 60, 64};

        bus.run = 0; bus.last_step = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
`ifdef SEQ_OCTAVE_EN
        bus.octave = 0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_trig",  int'(bus.trig), 0);
        chk("rst_latch", int'(bus.latch_cfg), 0);
        chk("rst_osc",   int'(bus.osc_count), 0);
        chk("rst_idx",   int'(bus.step_idx), 0);
        chk("rst_busy",  int'(bus.busy), 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", int'(bus.busy), 0);

        // Reset mid-play: everything clears without waiting for an edge, memory included
        wr(0, ent(2, 3, 'h123));
        bus.last_step = 0;
        bus.run = 1;
        wait_trig("rstplay_trig");
        #2;
        rstn = 1'b0;
        #1;
        chk("rstplay_trig",  int'(bus.trig), 0);
        chk("rstplay_latch", int'(bus.latch_cfg), 0);
        chk("rstplay_osc",   int'(bus.osc_count), 0);
        chk("rstplay_idx",   int'(bus.step_idx), 0);
        chk("rstplay_busy",  int'(bus.busy), 0);
        bus.run = 0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("rstplay_stays_idle", int'(bus.busy), 0);
        bus.run = 1;
        @(negedge clk);
        chk("rstplay_reload_latch", int'(bus.latch_cfg), 1);
        chk("rstplay_mem_cleared",  int'(bus.osc_count), 0);
        stop_play();

        // Vector table: step 0 under test, step 1 a marker {0,0,0x5A5}
        for (int v = 0; v < 7; v++) begin
            int lat, trg, per, bad;
            wr(0, ent(tbl[v].g, tbl[v].s, tbl[v].osc));
            wr(1, ent(0, 0, 'h5A5));
            bus.last_step = 1;
            bus.run = 1;
            lat = 0; trg = 0; per = 0; bad = 0;
            @(negedge clk);
            while (bus.step_idx == 0 && per < 200) begin
                per++;
                if (bus.latch_cfg) lat++;
                if (bus.trig) trg++;
                if (int'(bus.osc_count) != tbl[v].osc) bad++;
                @(negedge clk);
            end
            chk($sformatf("vec%0d_latch_cycles", v),  lat, tbl[v].exp_latch);
            chk($sformatf("vec%0d_trig_cycles", v),   trg, tbl[v].exp_trig);
            chk($sformatf("vec%0d_period", v),        per, tbl[v].exp_period);
            chk($sformatf("vec%0d_osc_bad", v),       bad, 0);
            chk($sformatf("vec%0d_next_latch", v),    int'(bus.latch_cfg), 1);
            chk($sformatf("vec%0d_next_trig", v),     int'(bus.trig), 0);
            chk($sformatf("vec%0d_next_osc", v),      int'(bus.osc_count), 'h5A5);
            stop_play();
        end

        // Step order with wrap, then last_step lowered while on step 2
        wr(0, ent(0, 0, 'h010));
        wr(1, ent(0, 0, 'h020));
        wr(2, ent(0, 0, 'h030));
        bus.last_step = 2;
        bus.run = 1;
        @(negedge clk);
        chk("seq_first_idx", int'(bus.step_idx), 0);
        next_step(idx); chk("seq_1", idx, 1);
        next_step(idx); chk("seq_2", idx, 2);
        chk("seq_2_osc", int'(bus.osc_count), 'h030);
        next_step(idx); chk("seq_wrap0", idx, 0);
        next_step(idx); chk("seq_1b", idx, 1);
        next_step(idx); chk("seq_2b", idx, 2);
        bus.last_step = 1;
        next_step(idx); chk("seq_lowered_wrap", idx, 0);
        next_step(idx); chk("seq_1c", idx, 1);
        next_step(idx); chk("seq_wrap_at_1", idx, 0);
        stop_play();

        // Short run glitch ignored, then stop taken only at the tick
        wr(0, ent(3, 3, 'h321));
        bus.last_step = 0;
        bus.run = 1;
        wait_trig("stop_wait_trig");
        bus.run = 0;
        @(negedge clk);
        bus.run = 1;
        chk("glitch_busy", int'(bus.busy), 1);
        chk("glitch_trig", int'(bus.trig), 1);
        bus.run = 0;
        @(negedge clk);
        chk("stop_pending1_trig", int'(bus.trig), 1);
        @(negedge clk);
        chk("stop_pending2_trig", int'(bus.trig), 1);
        @(negedge clk);
        chk("stop_at_tick_trig",  int'(bus.trig), 0);
        chk("stop_at_tick_busy",  int'(bus.busy), 0);
        chk("stop_at_tick_latch", int'(bus.latch_cfg), 0);
        chk("stop_at_tick_idx",   int'(bus.step_idx), 0);
        chk("stop_osc_held",      int'(bus.osc_count), 'h321);

        // Write to the playing step applies on its next visit
        wr(0, ent(0, 1, 'h111));
        wr(1, ent(0, 1, 'h222));
        bus.last_step = 1;
        bus.run = 1;
        @(negedge clk);
        chk("wrplay_first_osc", int'(bus.osc_count), 'h111);
        wr(0, ent(0, 1, 'h333));
        chk("wrplay_same_visit", int'(bus.osc_count), 'h111);
        next_step(idx);
        chk("wrplay_idx1", idx, 1);
        chk("wrplay_osc1", int'(bus.osc_count), 'h222);
        next_step(idx);
        chk("wrplay_idx0", idx, 0);
        chk("wrplay_new_osc", int'(bus.osc_count), 'h333);
        stop_play();

`ifdef SEQ_OCTAVE_EN
        wr(0, ent(0, 0, 'h400));
        wr(1, ent(0, 0, 'h002));
        bus.last_step = 1;
        bus.octave = 2;
        bus.run = 1;
        @(negedge clk);
        chk("oct2_osc", int'(bus.osc_count), 'h100);
        bus.octave = 3;
        next_step(idx);
        chk("oct3_floor_osc", int'(bus.osc_count), 'h001);
        stop_play();
        bus.octave = 0;
`endif

        // Random patterns against the step schedule model
        for (int it = 0; it < 4; it++) begin
            logic [19:0] pat[16];
            cyc_t        q[$];
            int          last, g, s, o, mi;
            last = $urandom_range(0, 15);
            for (int a = 0; a < 16; a++) begin
                pat[a] = ent($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4095));
                wr(a, pat[a]);
            end
            bus.last_step = 4'(last);
            q.delete();
            mi = 0;
            while (q.size() < NCYC) begin
                g = int'(pat[mi][19:16]);
                s = int'(pat[mi][15:12]);
                o = int'(pat[mi][11:0]);
`ifdef SEQ_OCTAVE_EN
                if (o == 0) o = 1;
`endif
                for (int k = 0; k < TD; k++) q.push_back('{0, 1, mi, o});
                for (int k = 0; k < g * TD; k++) q.push_back('{1, 0, mi, o});
                for (int k = 0; k < ((s > g) ? s - g : 0) * TD; k++) q.push_back('{0, 0, mi, o});
                mi = (mi >= last) ? 0 : mi + 1;
            end
            bus.run = 1;
            for (int c = 0; c < NCYC; c++) begin
                @(negedge clk);
                chk($sformatf("rand_it%0d_cyc%0d", it, c),
                    int'({bus.busy, bus.trig, bus.latch_cfg, bus.step_idx, bus.osc_count}),
                    int'({1'b1, 1'(q[c].trig), 1'(q[c].latch), 4'(q[c].idx), 12'(q[c].osc)}));
            end
            stop_play();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
